// File: rtl/mmu_mc_frontend_pkg.sv
// Shared constants and payload-width helpers for the multi-channel MMU front end.
package mmu_mc_frontend_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    function automatic int alloc_req_w(int id_w, int sz_w);
        return id_w + sz_w;
    endfunction

    function automatic int free_req_w(int id_w, int idx_w, int sz_w);
        return id_w + idx_w + sz_w;
    endfunction

    function automatic int alloc_rsp_w(int id_w, int idx_w, int fr_w, int sz_w);
        return id_w + idx_w + 1 + fr_w + 2 * sz_w;
    endfunction

    function automatic int free_rsp_w(int id_w, int fr_w, int sz_w);
        return id_w + 1 + fr_w + 2 * sz_w;
    endfunction

endpackage

// File: rtl/mmu_mc_frontend_path.sv
// One request/response path: arbiter, shared request FIFO, channel-tag FIFO and
// per-channel response FIFOs routing in-order core responses back to their issuer.
module mmu_mc_frontend_path
    import mmu_mc_frontend_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int REQ_W     = 17,
    parameter int RSP_W     = 39,
    parameter int REQ_DEPTH = 8,
    parameter int TAG_DEPTH = 16,
    parameter int RSP_DEPTH = 4,
    parameter int ARB_MODE  = ARB_RR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req_valid,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH*REQ_W-1:0] req_data,
    output logic [NUM_CH-1:0]       rsp_valid,
    input  logic [NUM_CH-1:0]       rsp_pop,
    output logic [NUM_CH*RSP_W-1:0] rsp_data,
    input  logic                    core_req_pop,
    output logic [REQ_W-1:0]        core_req_data,
    output logic                    core_req_empty,
    input  logic                    core_rsp_we,
    input  logic [RSP_W-1:0]        core_rsp_data,
    output logic                    core_rsp_afull,
    output logic                    err_orphan
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RQ_AW = $clog2(REQ_DEPTH);
    localparam int TG_AW = $clog2(TAG_DEPTH);
    localparam int RS_AW = $clog2(RSP_DEPTH);
    localparam logic [RQ_AW:0] RQ_FULL = (RQ_AW+1)'(REQ_DEPTH);
    localparam logic [TG_AW:0] TG_FULL = (TG_AW+1)'(TAG_DEPTH);
    localparam logic [RS_AW:0] RS_FULL = (RS_AW+1)'(RSP_DEPTH);
    localparam logic [RS_AW:0] RS_NEAR = (RS_AW+1)'(RSP_DEPTH - 1);

    logic [CH_W-1:0]  ptr, winner, tg_head;
    logic             grant_any, grant;
    logic [REQ_W-1:0] rq_mem [REQ_DEPTH];
    logic [RQ_AW-1:0] rq_wp, rq_rp;
    logic [RQ_AW:0]   rq_cnt;
    logic [CH_W-1:0]  tg_mem [TAG_DEPTH];
    logic [TG_AW-1:0] tg_wp, tg_rp;
    logic [TG_AW:0]   tg_cnt;
    logic             rq_pop, tg_pop, orphan;
    logic [NUM_CH-1:0] ovf, near_full;

    function automatic logic [CH_W-1:0] arb_idx(logic [CH_W-1:0] base, int k);
        int s;
        s = (ARB_MODE == ARB_FIXED) ? k : int'(base) + k;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // Grant is suppressed while either FIFO is (registered) full, and during reset.
    always_comb begin
        winner    = '0;
        grant_any = 1'b0;
        req_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_any && req_valid[arb_idx(ptr, k)]) begin
                grant_any = 1'b1;
                winner    = arb_idx(ptr, k);
            end
        end
        grant = grant_any && (rq_cnt != RQ_FULL) && (tg_cnt != TG_FULL) && !rst;
        if (grant) req_ready[winner] = 1'b1;
    end

    assign rq_pop         = core_req_pop && (rq_cnt != '0);
    assign tg_pop         = core_rsp_we && (tg_cnt != '0);
    assign orphan         = core_rsp_we && (tg_cnt == '0);
    assign tg_head        = tg_mem[tg_rp];
    assign core_req_data  = rq_mem[rq_rp];
    assign core_req_empty = (rq_cnt == '0);
    assign core_rsp_afull = |near_full;

    always_ff @(posedge clk) begin
        if (grant) begin
            rq_mem[rq_wp] <= req_data[int'(winner)*REQ_W +: REQ_W];
            tg_mem[tg_wp] <= winner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            rq_wp      <= '0;
            rq_rp      <= '0;
            rq_cnt     <= '0;
            tg_wp      <= '0;
            tg_rp      <= '0;
            tg_cnt     <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (grant) begin
                ptr   <= (int'(winner) == NUM_CH - 1) ? '0 : winner + 1'b1;
                rq_wp <= rq_wp + 1'b1;
                tg_wp <= tg_wp + 1'b1;
            end
            if (rq_pop) rq_rp <= rq_rp + 1'b1;
            if (tg_pop) tg_rp <= tg_rp + 1'b1;
            case ({grant, rq_pop})
                2'b10:   rq_cnt <= rq_cnt + 1'b1;
                2'b01:   rq_cnt <= rq_cnt - 1'b1;
                default: ;
            endcase
            case ({grant, tg_pop})
                2'b10:   tg_cnt <= tg_cnt + 1'b1;
                2'b01:   tg_cnt <= tg_cnt - 1'b1;
                default: ;
            endcase
            if (orphan || (|ovf)) err_orphan <= 1'b1;
        end
    end

    // Per-channel response FIFOs; a write to a full FIFO is dropped and flagged.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_rsp
        logic [RSP_W-1:0] mem [RSP_DEPTH];
        logic [RS_AW-1:0] wp, rp;
        logic [RS_AW:0]   cnt;
        logic             hit, push, pop;

        assign hit          = tg_pop && (tg_head == CH_W'(i));
        assign push         = hit && (cnt != RS_FULL);
        assign pop          = rsp_pop[i] && (cnt != '0);
        assign ovf[i]       = hit && (cnt == RS_FULL);
        assign near_full[i] = (cnt >= RS_NEAR);
        assign rsp_valid[i] = (cnt != '0);
        assign rsp_data[i*RSP_W +: RSP_W] = mem[rp];

        always_ff @(posedge clk) begin
            if (push) mem[wp] <= core_rsp_data;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (push) wp <= wp + 1'b1;
                if (pop)  rp <= rp + 1'b1;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/mmu_mc_frontend.sv
// Multi-channel MMU front end: independent alloc and free paths sharing one core
// request/response stream each, with per-channel ports and response routing.
module mmu_mc_frontend
    import mmu_mc_frontend_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ID_W      = 13,
    parameter int IDX_W     = 15,
    parameter int SZ_W      = 4,
    parameter int FR_W      = 2,
    parameter int REQ_DEPTH = 8,
    parameter int TAG_DEPTH = 16,
    parameter int RSP_DEPTH = 4,
    parameter int ARB_MODE  = ARB_RR,
    localparam int AQ_W = alloc_req_w(ID_W, SZ_W),
    localparam int FQ_W = free_req_w(ID_W, IDX_W, SZ_W),
    localparam int AS_W = alloc_rsp_w(ID_W, IDX_W, FR_W, SZ_W),
    localparam int FS_W = free_rsp_w(ID_W, FR_W, SZ_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      ch_alloc_req_valid,
    output logic [NUM_CH-1:0]      ch_alloc_req_ready,
    input  logic [NUM_CH*AQ_W-1:0] ch_alloc_req_data,
    input  logic [NUM_CH-1:0]      ch_free_req_valid,
    output logic [NUM_CH-1:0]      ch_free_req_ready,
    input  logic [NUM_CH*FQ_W-1:0] ch_free_req_data,
    output logic [NUM_CH-1:0]      ch_alloc_rsp_valid,
    input  logic [NUM_CH-1:0]      ch_alloc_rsp_pop,
    output logic [NUM_CH*AS_W-1:0] ch_alloc_rsp_data,
    output logic [NUM_CH-1:0]      ch_free_rsp_valid,
    input  logic [NUM_CH-1:0]      ch_free_rsp_pop,
    output logic [NUM_CH*FS_W-1:0] ch_free_rsp_data,
    input  logic                   core_alloc_req_pop,
    output logic [AQ_W-1:0]        core_alloc_req_data,
    output logic                   core_alloc_req_empty,
    input  logic                   core_alloc_rsp_we,
    input  logic [AS_W-1:0]        core_alloc_rsp_data,
    output logic                   core_alloc_rsp_afull,
    input  logic                   core_free_req_pop,
    output logic [FQ_W-1:0]        core_free_req_data,
    output logic                   core_free_req_empty,
    input  logic                   core_free_rsp_we,
    input  logic [FS_W-1:0]        core_free_rsp_data,
    output logic                   core_free_rsp_afull,
    output logic [1:0]             err_orphan_rsp
);

    mmu_mc_frontend_path #(
        .NUM_CH(NUM_CH), .REQ_W(AQ_W), .RSP_W(AS_W), .REQ_DEPTH(REQ_DEPTH),
        .TAG_DEPTH(TAG_DEPTH), .RSP_DEPTH(RSP_DEPTH), .ARB_MODE(ARB_MODE)
    ) u_alloc (
        .clk(clk), .rst(rst),
        .req_valid(ch_alloc_req_valid), .req_ready(ch_alloc_req_ready), .req_data(ch_alloc_req_data),
        .rsp_valid(ch_alloc_rsp_valid), .rsp_pop(ch_alloc_rsp_pop), .rsp_data(ch_alloc_rsp_data),
        .core_req_pop(core_alloc_req_pop), .core_req_data(core_alloc_req_data),
        .core_req_empty(core_alloc_req_empty), .core_rsp_we(core_alloc_rsp_we),
        .core_rsp_data(core_alloc_rsp_data), .core_rsp_afull(core_alloc_rsp_afull),
        .err_orphan(err_orphan_rsp[0])
    );

    mmu_mc_frontend_path #(
        .NUM_CH(NUM_CH), .REQ_W(FQ_W), .RSP_W(FS_W), .REQ_DEPTH(REQ_DEPTH),
        .TAG_DEPTH(TAG_DEPTH), .RSP_DEPTH(RSP_DEPTH), .ARB_MODE(ARB_MODE)
    ) u_free (
        .clk(clk), .rst(rst),
        .req_valid(ch_free_req_valid), .req_ready(ch_free_req_ready), .req_data(ch_free_req_data),
        .rsp_valid(ch_free_rsp_valid), .rsp_pop(ch_free_rsp_pop), .rsp_data(ch_free_rsp_data),
        .core_req_pop(core_free_req_pop), .core_req_data(core_free_req_data),
        .core_req_empty(core_free_req_empty), .core_rsp_we(core_free_rsp_we),
        .core_rsp_data(core_free_rsp_data), .core_rsp_afull(core_free_rsp_afull),
        .err_orphan(err_orphan_rsp[1])
    );

endmodule

// File: tb/tb_mmu_mc_frontend.sv
// Bench for mmu_mc_frontend: directed scenarios plus randomized traffic, all checked
// against a queue-based reference model of both paths.
module tb_mmu_mc_frontend;

    localparam int NC = 4;
    localparam int AQW = 17, FQW = 32, ASW = 39, FSW = 24;
    localparam int REQ_D = 8, TAG_D = 16, RSP_D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NC-1:0]     a_valid, a_ready, f_valid, f_ready;
    logic [NC-1:0]     a_rvalid, a_rpop, f_rvalid, f_rpop;
    logic [NC*AQW-1:0] a_data;
    logic [NC*FQW-1:0] f_data;
    logic [NC*ASW-1:0] a_rdata;
    logic [NC*FSW-1:0] f_rdata;
    logic              c_apop, c_aempty, c_awe, c_aafull;
    logic              c_fpop, c_fempty, c_fwe, c_fafull;
    logic [AQW-1:0]    c_adata;
    logic [FQW-1:0]    c_fdata;
    logic [ASW-1:0]    c_awdata;
    logic [FSW-1:0]    c_fwdata;
    logic [1:0]        err;

    mmu_mc_frontend #(
        .NUM_CH(NC), .ID_W(13), .IDX_W(15), .SZ_W(4), .FR_W(2),
        .REQ_DEPTH(REQ_D), .TAG_DEPTH(TAG_D), .RSP_DEPTH(RSP_D), .ARB_MODE(0)
    ) dut (
        .clk(clk), .rst(rst),
        .ch_alloc_req_valid(a_valid), .ch_alloc_req_ready(a_ready), .ch_alloc_req_data(a_data),
        .ch_free_req_valid(f_valid), .ch_free_req_ready(f_ready), .ch_free_req_data(f_data),
        .ch_alloc_rsp_valid(a_rvalid), .ch_alloc_rsp_pop(a_rpop), .ch_alloc_rsp_data(a_rdata),
        .ch_free_rsp_valid(f_rvalid), .ch_free_rsp_pop(f_rpop), .ch_free_rsp_data(f_rdata),
        .core_alloc_req_pop(c_apop), .core_alloc_req_data(c_adata), .core_alloc_req_empty(c_aempty),
        .core_alloc_rsp_we(c_awe), .core_alloc_rsp_data(c_awdata), .core_alloc_rsp_afull(c_aafull),
        .core_free_req_pop(c_fpop), .core_free_req_data(c_fdata), .core_free_req_empty(c_fempty),
        .core_free_rsp_we(c_fwe), .core_free_rsp_data(c_fwdata), .core_free_rsp_afull(c_fafull),
        .err_orphan_rsp(err)
    );

    // Reference model: per path (0 = alloc, 1 = free) queues of payloads and issuing channels.
    logic [63:0] m_req [2][$];
    int          m_tag [2][$];
    logic [63:0] m_rsp [2][NC][$];
    int          m_ptr [2];
    logic        m_err [2];
    logic [NC-1:0] cap_rdy [2];
    string       pn [2] = '{"alloc", "free"};

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            m_req[p].delete();
            m_tag[p].delete();
            for (int c = 0; c < NC; c++) m_rsp[p][c].delete();
            m_ptr[p] = 0;
            m_err[p] = 1'b0;
        end
    endtask

    task automatic idle();
        a_valid = '0; f_valid = '0; a_rpop = '0; f_rpop = '0;
        a_data = '0; f_data = '0;
        c_apop = 1'b0; c_awe = 1'b0; c_awdata = '0;
        c_fpop = 1'b0; c_fwe = 1'b0; c_fwdata = '0;
    endtask

    // Called at a falling edge with inputs applied; checks, advances the model, returns at the next falling edge.
    task automatic step();
        logic [NC-1:0] v, rdy, rv, rp;
        logic          pop, we, empty, afull;
        logic [63:0]   head, wd;
        logic [63:0]   qd [NC];
        logic [63:0]   rd [NC];
        logic          rpok [NC];
        int            win, dst;
        logic          popok, exp_af;
        #1;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) begin
                v = a_valid; rdy = a_ready; rv = a_rvalid; rp = a_rpop; pop = c_apop; we = c_awe;
                empty = c_aempty; afull = c_aafull; head = 64'(c_adata); wd = 64'(c_awdata);
                for (int c = 0; c < NC; c++) begin
                    qd[c] = 64'(a_data[c*AQW +: AQW]);
                    rd[c] = 64'(a_rdata[c*ASW +: ASW]);
                end
            end else begin
                v = f_valid; rdy = f_ready; rv = f_rvalid; rp = f_rpop; pop = c_fpop; we = c_fwe;
                empty = c_fempty; afull = c_fafull; head = 64'(c_fdata); wd = 64'(c_fwdata);
                for (int c = 0; c < NC; c++) begin
                    qd[c] = 64'(f_data[c*FQW +: FQW]);
                    rd[c] = 64'(f_rdata[c*FSW +: FSW]);
                end
            end
            win = -1;
            if (m_req[p].size() < REQ_D && m_tag[p].size() < TAG_D)
                for (int k = 0; k < NC; k++)
                    if (win < 0 && v[(m_ptr[p] + k) % NC]) win = (m_ptr[p] + k) % NC;
            cap_rdy[p] = rdy;
            chk($sformatf("%s_ready", pn[p]), 64'(rdy), (win < 0) ? 64'd0 : (64'd1 << win));
            chk($sformatf("%s_core_empty", pn[p]), 64'(empty), 64'(m_req[p].size() == 0));
            if (m_req[p].size() > 0) chk($sformatf("%s_core_head", pn[p]), head, m_req[p][0]);
            exp_af = 1'b0;
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("%s_rsp_valid%0d", pn[p], c), 64'(rv[c]), 64'(m_rsp[p][c].size() > 0));
                if (m_rsp[p][c].size() > 0) chk($sformatf("%s_rsp_data%0d", pn[p], c), rd[c], m_rsp[p][c][0]);
                if (m_rsp[p][c].size() >= RSP_D - 1) exp_af = 1'b1;
            end
            chk($sformatf("%s_afull", pn[p]), 64'(afull), 64'(exp_af));
            chk($sformatf("%s_err", pn[p]), 64'(err[p]), 64'(m_err[p]));

            popok = pop && (m_req[p].size() > 0);
            if (win >= 0) m_req[p].push_back(qd[win]);
            if (popok) void'(m_req[p].pop_front());
            for (int c = 0; c < NC; c++) rpok[c] = rp[c] && (m_rsp[p][c].size() > 0);
            dst = -1;
            if (we) begin
                if (m_tag[p].size() > 0) begin
                    dst = m_tag[p].pop_front();
                    if (m_rsp[p][dst].size() >= RSP_D) begin
                        m_err[p] = 1'b1;
                        dst = -1;
                    end
                end else begin
                    m_err[p] = 1'b1;
                end
            end
            if (win >= 0) begin
                m_tag[p].push_back(win);
                m_ptr[p] = (win + 1) % NC;
            end
            for (int c = 0; c < NC; c++) if (rpok[c]) void'(m_rsp[p][c].pop_front());
            if (dst >= 0) m_rsp[p][dst].push_back(wd);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ready", 64'({a_ready, f_ready}), 64'd0);
        chk("rst_rsp_valid", 64'({a_rvalid, f_rvalid}), 64'd0);
        chk("rst_core_empty", 64'({c_aempty, c_fempty}), 64'd3);
        chk("rst_afull", 64'({c_aafull, c_fafull}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_inputs();
        a_valid = NC'($urandom);
        f_valid = NC'($urandom);
        for (int c = 0; c < NC; c++) begin
            a_data[c*AQW +: AQW] = AQW'($urandom);
            f_data[c*FQW +: FQW] = FQW'($urandom);
        end
        a_rpop   = NC'($urandom);
        f_rpop   = NC'($urandom);
        c_apop   = ($urandom_range(0, 3) != 0);
        c_fpop   = ($urandom_range(0, 3) != 0);
        c_awe    = (m_tag[0].size() > 0 && !c_aafull && $urandom_range(0, 1) == 1) || ($urandom_range(0, 63) == 0);
        c_fwe    = (m_tag[1].size() > 0 && !c_fafull && $urandom_range(0, 1) == 1) || ($urandom_range(0, 63) == 0);
        c_awdata = ASW'({$urandom, $urandom});
        c_fwdata = FSW'($urandom);
    endtask

    int n;

    initial begin
        idle();
        model_clear();
        @(negedge clk);
        do_reset();

        // Round-robin fairness with all channels requesting.
        a_valid = '1; c_apop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_order", 64'(cap_rdy[0]), 64'd1 << (k % 4));
        end

        // Reset mid-traffic (outstanding tags and requests pending).
        a_valid = '1; f_valid = '1; c_apop = 1'b0;
        step();
        do_reset();
        idle();

        // Routing back to the issuing channel.
        a_valid = 4'b0100; a_data[2*AQW +: AQW] = {4'd1, 13'h15}; step();
        a_valid = 4'b0001; a_data[0 +: AQW] = {4'd2, 13'h3}; c_apop = 1'b1; step();
        a_valid = '0; step();
        c_apop = 1'b0; c_awe = 1'b1; c_awdata = ASW'(13'h15); step();
        c_awdata = ASW'(13'h3) | (ASW'(1) << 13); step();
        c_awe = 1'b0; step();
        chk("route_valid", 64'(a_rvalid), 64'b0101);
        chk("route_ch2_id", 64'(a_rdata[2*ASW +: 13]), 64'h15);
        chk("route_ch0_id", 64'(a_rdata[0 +: 13]), 64'h3);

        // Request FIFO back-pressure.
        do_reset(); idle();
        a_valid = '1; n = 0;
        repeat (10) begin step(); if (cap_rdy[0] != 0) n++; end
        chk("bp_grants", 64'(n), 64'd8);
        chk("bp_ready_low", 64'(a_ready), 64'd0);
        c_apop = 1'b1; step();
        chk("bp_pop_cycle", 64'(cap_rdy[0]), 64'd0);
        c_apop = 1'b0; n = 0;
        repeat (3) begin step(); if (cap_rdy[0] != 0) n++; end
        chk("bp_one_more", 64'(n), 64'd1);

        // Tag FIFO limit with the request FIFO drained.
        do_reset(); idle();
        a_valid = '1; c_apop = 1'b1; n = 0;
        repeat (20) begin step(); if (cap_rdy[0] != 0) n++; end
        chk("tag_grants", 64'(n), 64'd16);
        chk("tag_ready_low", 64'(a_ready), 64'd0);
        chk("tag_req_empty", 64'(c_aempty), 64'd1);
        c_awe = 1'b1; c_awdata = ASW'(13'h7); step();
        c_awe = 1'b0; n = 0;
        repeat (3) begin step(); if (cap_rdy[0] != 0) n++; end
        chk("tag_one_more", 64'(n), 64'd1);

        // Orphan response on the free path.
        do_reset(); idle();
        c_fwe = 1'b1; step();
        c_fwe = 1'b0;
        chk("orphan_err", 64'(err), 64'b10);
        chk("orphan_no_valid", 64'(f_rvalid), 64'd0);

        // Grant and response in the same cycle leave the outstanding count unchanged.
        do_reset(); idle();
        a_valid = 4'b0001; step();
        c_awe = 1'b1; c_awdata = ASW'(13'h11); step();
        a_valid = '0; c_awdata = ASW'(13'h12); step();
        c_awe = 1'b0;
        chk("simul_no_err", 64'(err), 64'd0);
        chk("simul_valid", 64'(a_rvalid[0]), 64'd1);
        c_awe = 1'b1; step();
        c_awe = 1'b0;
        chk("simul_orphan", 64'(err), 64'b01);

        // Randomized traffic on both paths with a reset part-way through.
        do_reset(); idle();
        for (int i = 0; i < 1600; i++) begin
            rand_inputs();
            if (i == 800) do_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
